pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter and decides each cycle which fetch address comes next: sequential PC+4, branch target, J/JAL target or JR register target.
- Forms the 26-bit jump target as {PC+4[31:28], target, 2'b00}.
- Sits between the control/decoder outputs and the instruction memory address port.
- Adds stall handling, a redirect indicator, a misaligned-JR error flag and optional MIPS branch-delay-slot sequencing.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and all state this cycle; control inputs ignored
jump  input  1  J/JAL decoded this cycle
jump_target  input  26  instr[25:0] of the jump
branch_taken  input  1  conditional branch resolved taken this cycle
branch_offset  input  16  instr[15:0], signed word offset
jr  input  1  JR decoded this cycle
jr_addr  input  32  register value for JR
pc  output  32  current fetch address
pc_plus4  output  32  pc + 4 (combinational, for JAL link)
redirect  output  1  registered pulse: pc was just loaded with a non-sequential target
addr_err  output  1  sticky: a JR target had nonzero bits [1:0]

Behaviour:
- Reset:
  - pc = RESET_PC; redirect = 0; addr_err = 0; delay-slot state = SEQ; pending target = 0.
  - Reset has priority over stall and over every other input.
- pc_plus4 = pc + 32'd4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Target arithmetic:
  - jump: {pc_plus4[31:28], jump_target, 2'b00}.
  - branch: pc_plus4 + sign-extended {branch_offset, 2'b00}, 32-bit, wrap on overflow.
  - jr: {jr_addr[31:2], 2'b00}.
- JR misalignment: if jr_addr[1:0] != 0 when the JR is accepted, set addr_err; it stays set until reset.
- Priority when several control inputs are asserted together: jr > jump > branch_taken > sequential.
- Stall:
  - When stall = 1: pc, state, pending target and addr_err hold, and redirect = 0 next cycle.
  - Control inputs are not sampled during stall; the decoder must re-present them.
- Latency: one cycle. A control input accepted in cycle N gives the new pc in cycle N+1.
- redirect is 1 in exactly the cycle after pc loads a non-sequential target. Otherwise 0.

Optional Feature:
- Macro DELAY_SLOT_EN.
- Without the macro:
  - Every accepted jr/jump/branch_taken loads the selected target directly into pc on the next edge.
  - There is no state machine; the state is fixed at SEQ.
- With the macro (two-state FSM, SEQ and SLOT):
  - SEQ, redirect request accepted: pending <= target (computed from the current pc_plus4); pc <= pc_plus4 (the delay-slot instruction); state <= SLOT; redirect = 0.
  - SEQ, no request: pc <= pc_plus4.
  - SLOT, no stall: pc <= pending; state <= SEQ; redirect = 1 next cycle.
    - Control inputs are ignored in SLOT; a branch placed in a delay slot has no effect.
    - addr_err is not updated in SLOT.
  - SLOT with stall: hold.
  - reset in SLOT: the pending redirect is discarded and pc = RESET_PC.

Test Plan:
1. Reset with RESET_PC = 32'h0040_0000, then 3 unstalled cycles → pc = 0040_0000, 0040_0004, 0040_0008, 0040_000C; redirect stays 0.
2. pc = 32'h1000_0010, jump = 1, jump_target = 26'h0000100 → next pc = 32'h1000_0400, redirect = 1 for one cycle.
3. pc = 32'h0000_0100, branch_taken = 1, branch_offset = 16'hFFFE → next pc = 32'h0000_00FC; with offset 16'h0003 → 32'h0000_0110.
4. jr = 1 with jump = 1 and branch_taken = 1 together, jr_addr = 32'h0000_2003 → pc = 32'h0000_2000 and addr_err = 1. addr_err stays 1 through later cycles until reset.
5. stall held 3 cycles while jump = 1 → pc unchanged and redirect = 0. After stall deasserts, jump is accepted and redirect pulses once.
6. DELAY_SLOT_EN build: pc = 32'h0000_0040, branch_taken with offset 16'h0004 → pc sequence 0x44, then 0x54. A branch asserted during the 0x44 cycle is ignored. A reset asserted during SLOT gives pc = RESET_PC with no later jump to 0x54.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Owns the program counter and selects the next fetch address
//             each cycle: sequential PC+4, branch target, J/JAL target or
//             JR register target. Provides stall handling, a one-cycle
//             redirect pulse and a sticky misaligned-JR error flag.
//  Options  : DELAY_SLOT_EN - when defined, redirects are taken after one
//             MIPS branch-delay-slot instruction (SEQ/SLOT state machine).
//             When undefined, redirects load pc directly.
//  Ports    : clk           - system clock, rising edge
//             reset         - synchronous active-high reset
//             stall         - hold all state; control inputs not sampled
//             jump          - J/JAL decoded
//             jump_target   - instr[25:0] of the jump
//             branch_taken  - conditional branch resolved taken
//             branch_offset - instr[15:0], signed word offset
//             jr            - JR decoded
//             jr_addr       - register value for JR
//             pc            - current fetch address
//             pc_plus4      - pc + 4 (combinational, JAL link value)
//             redirect      - pc was just loaded with a non-sequential target
//             addr_err      - sticky: an accepted JR had jr_addr[1:0] != 0
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        addr_err
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    // Registered state
    logic [31:0] r_pc_q;
    logic        r_redirect_q;
    logic        r_addr_err_q;

    // Next-state values
    logic [31:0] w_pc_d;
    logic        w_redirect_d;
    logic        w_addr_err_d;

    // Target datapath
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jr_tgt;
    logic [31:0] w_target;
    logic        w_req;
    logic        w_jr_misalign;

`ifdef DELAY_SLOT_EN
    typedef enum logic [0:0] {
        ST_SEQ  = 1'b0,
        ST_SLOT = 1'b1
    } state_t;

    state_t      r_state_q;
    state_t      w_state_d;
    logic [31:0] r_pending_q;
    logic [31:0] w_pending_d;
`endif

    // ------------------------------------------------------------------
    // Target arithmetic. All targets are relative to pc+4 (the address
    // of the delay-slot instruction in MIPS terms), wrapping mod 2^32.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_plus4   = r_pc_q + c_PC_STEP;
        w_jump_tgt   = {w_pc_plus4[31:28], jump_target, 2'b00};
        w_branch_tgt = w_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        w_jr_tgt     = {jr_addr[31:2], 2'b00};

        // Priority: jr > jump > branch_taken
        w_req = jr | jump | branch_taken;
        if (jr) begin
            w_target = w_jr_tgt;
        end else if (jump) begin
            w_target = w_jump_tgt;
        end else begin
            w_target = w_branch_tgt;
        end

        // jr has top priority, so jr=1 always means the JR is the one taken
        w_jr_misalign = jr && (jr_addr[1:0] != 2'b00);
    end

    // ------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_d       = r_pc_q;
        w_redirect_d = 1'b0;
        w_addr_err_d = r_addr_err_q;
`ifdef DELAY_SLOT_EN
        w_state_d    = r_state_q;
        w_pending_d  = r_pending_q;
`endif
        if (!stall) begin
`ifdef DELAY_SLOT_EN
            if (r_state_q == ST_SLOT) begin
                // Delay slot already issued: take the saved target. Control
                // inputs seen here belong to the slot instruction and are
                // deliberately dropped.
                w_pc_d       = r_pending_q;
                w_state_d    = ST_SEQ;
                w_redirect_d = 1'b1;
            end else begin
                w_pc_d = w_pc_plus4;
                if (w_req) begin
                    w_pending_d = w_target;
                    w_state_d   = ST_SLOT;
                    if (w_jr_misalign) begin
                        w_addr_err_d = 1'b1;
                    end
                end
            end
`else
            if (w_req) begin
                w_pc_d       = w_target;
                w_redirect_d = 1'b1;
                if (w_jr_misalign) begin
                    w_addr_err_d = 1'b1;
                end
            end else begin
                w_pc_d = w_pc_plus4;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers; reset overrides stall and all control inputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_q       <= RESET_PC;
            r_redirect_q <= 1'b0;
            r_addr_err_q <= 1'b0;
`ifdef DELAY_SLOT_EN
            r_state_q    <= ST_SEQ;
            r_pending_q  <= 32'h0000_0000;
`endif
        end else begin
            r_pc_q       <= w_pc_d;
            r_redirect_q <= w_redirect_d;
            r_addr_err_q <= w_addr_err_d;
`ifdef DELAY_SLOT_EN
            r_state_q    <= w_state_d;
            r_pending_q  <= w_pending_d;
`endif
        end
    end

    assign pc       = r_pc_q;
    assign pc_plus4 = w_pc_plus4;
    assign redirect = r_redirect_q;
    assign addr_err = r_addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed self-checking bench for pc_sequencer. Expected values
//             are hand-computed constants. Build with DELAY_SLOT_EN defined
//             to exercise the delay-slot sequencing instead of the direct
//             redirect scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] c_RST_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jump;
    logic [25:0] jump_target;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        addr_err;

    int n_vec;
    int n_err;

    pc_sequencer #(
        .RESET_PC (c_RST_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .redirect      (redirect),
        .addr_err      (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall         = 1'b0;
        jump          = 1'b0;
        jump_target   = 26'h0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0;
        jr            = 1'b0;
        jr_addr       = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Load pc directly with an aligned JR (non-delay-slot build).
    task automatic load_pc(input logic [31:0] addr);
        jr      = 1'b1;
        jr_addr = addr;
        step();
        clear_ctrl();
    endtask

    task automatic test_reset();
        clear_ctrl();
        do_reset();
        n_vec++;
        if (pc !== c_RST_PC) begin
            n_err++;
            $display("FAIL reset_pc: got %h expected %h", pc, c_RST_PC);
        end
        n_vec++;
        if (redirect !== 1'b0 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got redirect=%b addr_err=%b expected 0 0", redirect, addr_err);
        end
        n_vec++;
        if (pc_plus4 !== 32'h0040_0004) begin
            n_err++;
            $display("FAIL reset_pc_plus4: got %h expected %h", pc_plus4, 32'h0040_0004);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_vec++;
            if (pc !== c_RST_PC + 32'(4 * i) || redirect !== 1'b0) begin
                n_err++;
                $display("FAIL seq_step%0d: got pc=%h redirect=%b expected pc=%h redirect=0",
                         i, pc, redirect, c_RST_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_jump();
        load_pc(32'h1000_0010);
        jump        = 1'b1;
        jump_target = 26'h0000100;
        step();
        clear_ctrl();
        n_vec++;
        if (pc !== 32'h1000_0400 || redirect !== 1'b1) begin
            n_err++;
            $display("FAIL jump_target: got pc=%h redirect=%b expected pc=10000400 redirect=1", pc, redirect);
        end
        step();
        n_vec++;
        if (pc !== 32'h1000_0404 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL jump_after: got pc=%h redirect=%b expected pc=10000404 redirect=0", pc, redirect);
        end
    endtask

    task automatic test_branch();
        load_pc(32'h0000_0100);
        branch_taken  = 1'b1;
        branch_offset = 16'hFFFE;
        step();
        clear_ctrl();
        n_vec++;
        if (pc !== 32'h0000_00FC || redirect !== 1'b1) begin
            n_err++;
            $display("FAIL branch_neg: got pc=%h redirect=%b expected pc=000000fc redirect=1", pc, redirect);
        end
        load_pc(32'h0000_0100);
        branch_taken  = 1'b1;
        branch_offset = 16'h0003;
        step();
        clear_ctrl();
        n_vec++;
        if (pc !== 32'h0000_0110) begin
            n_err++;
            $display("FAIL branch_pos: got pc=%h expected 00000110", pc);
        end
    endtask

    task automatic test_priority_jr();
        load_pc(32'h0000_0300);
        jr            = 1'b1;
        jr_addr       = 32'h0000_2003;
        jump          = 1'b1;
        jump_target   = 26'h0000040;
        branch_taken  = 1'b1;
        branch_offset = 16'h0010;
        step();
        clear_ctrl();
        n_vec++;
        if (pc !== 32'h0000_2000 || addr_err !== 1'b1) begin
            n_err++;
            $display("FAIL jr_priority: got pc=%h addr_err=%b expected pc=00002000 addr_err=1", pc, addr_err);
        end
        // jump beats branch when jr is absent
        jump          = 1'b1;
        jump_target   = 26'h0000040;
        branch_taken  = 1'b1;
        branch_offset = 16'h0010;
        step();
        clear_ctrl();
        n_vec++;
        if (pc !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL jump_over_branch: got pc=%h expected 00000100", pc);
        end
        step();
        step();
        n_vec++;
        if (addr_err !== 1'b1) begin
            n_err++;
            $display("FAIL addr_err_sticky: got %b expected 1", addr_err);
        end
        do_reset();
        n_vec++;
        if (addr_err !== 1'b0 || pc !== c_RST_PC) begin
            n_err++;
            $display("FAIL addr_err_reset: got addr_err=%b pc=%h expected 0 %h", addr_err, pc, c_RST_PC);
        end
    endtask

    task automatic test_stall();
        // pc = RESET_PC after the preceding reset
        stall       = 1'b1;
        jump        = 1'b1;
        jump_target = 26'h0000003;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (pc !== c_RST_PC || redirect !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d: got pc=%h redirect=%b expected pc=%h redirect=0",
                         i, pc, redirect, c_RST_PC);
            end
        end
        stall = 1'b0;
        step();
        clear_ctrl();
        n_vec++;
        if (pc !== 32'h0000_000C || redirect !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got pc=%h redirect=%b expected pc=0000000c redirect=1", pc, redirect);
        end
        step();
        n_vec++;
        if (pc !== 32'h0000_0010 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL stall_pulse_once: got pc=%h redirect=%b expected pc=00000010 redirect=0", pc, redirect);
        end
        // reset wins over stall
        stall = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b0;
        n_vec++;
        if (pc !== c_RST_PC) begin
            n_err++;
            $display("FAIL reset_over_stall: got pc=%h expected %h", pc, c_RST_PC);
        end
    endtask

    task automatic test_wrap();
        load_pc(32'hFFFF_FFFC);
        n_vec++;
        if (pc_plus4 !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL wrap_plus4: got %h expected 00000000", pc_plus4);
        end
        step();
        n_vec++;
        if (pc !== 32'h0000_0000 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pc: got pc=%h redirect=%b expected pc=00000000 redirect=0", pc, redirect);
        end
    endtask

`ifdef DELAY_SLOT_EN
    task automatic test_delay_slot();
        clear_ctrl();
        do_reset();
        // Reach pc = 0x40 through a delayed JR
        jr      = 1'b1;
        jr_addr = 32'h0000_0040;
        step();
        clear_ctrl();
        n_vec++;
        if (pc !== 32'h0040_0004 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL ds_jr_slot: got pc=%h redirect=%b expected pc=00400004 redirect=0", pc, redirect);
        end
        step();
        n_vec++;
        if (pc !== 32'h0000_0040 || redirect !== 1'b1) begin
            n_err++;
            $display("FAIL ds_jr_taken: got pc=%h redirect=%b expected pc=00000040 redirect=1", pc, redirect);
        end
        branch_taken  = 1'b1;
        branch_offset = 16'h0004;
        step();
        n_vec++;
        if (pc !== 32'h0000_0044 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL ds_branch_slot: got pc=%h redirect=%b expected pc=00000044 redirect=0", pc, redirect);
        end
        // Requests in the slot are ignored, including a misaligned JR
        branch_offset = 16'h0100;
        jr            = 1'b1;
        jr_addr       = 32'h0000_0103;
        step();
        clear_ctrl();
        n_vec++;
        if (pc !== 32'h0000_0054 || redirect !== 1'b1 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL ds_branch_taken: got pc=%h redirect=%b addr_err=%b expected pc=00000054 redirect=1 addr_err=0",
                     pc, redirect, addr_err);
        end
        step();
        n_vec++;
        if (pc !== 32'h0000_0058 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL ds_after: got pc=%h redirect=%b expected pc=00000058 redirect=0", pc, redirect);
        end
        // Reset while in SLOT drops the pending target
        branch_taken  = 1'b1;
        branch_offset = 16'h0004;
        step();
        clear_ctrl();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++;
        if (pc !== c_RST_PC) begin
            n_err++;
            $display("FAIL ds_reset_slot: got pc=%h expected %h", pc, c_RST_PC);
        end
        step();
        step();
        n_vec++;
        if (pc !== c_RST_PC + 32'd8 || redirect !== 1'b0) begin
            n_err++;
            $display("FAIL ds_no_stale: got pc=%h redirect=%b expected pc=%h redirect=0",
                     pc, redirect, c_RST_PC + 32'd8);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        clear_ctrl();
        test_reset();
`ifdef DELAY_SLOT_EN
        test_delay_slot();
`else
        test_jump();
        test_branch();
        test_priority_jr();
        test_stall();
        test_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
